// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 serial transmitter fed by a small byte FIFO.
// Bit timing comes from a fractional phase accumulator. Queued bytes go out
// back-to-back: the stop-bit tick pops the next byte directly into a start bit.
//
// Handshake: a byte is accepted on any posedge where TxD_start && TxD_ready.
// TxD_ready is a register that is low only while the FIFO holds FifoDepth
// bytes. A strobe while TxD_ready is low is ignored and the byte is dropped.
// TxD_data only matters on the accepting edge.
module uart_tx_fifo #(
  parameter int ClkFrequency          = 25000000,
  parameter int Baud                  = 115200,
  parameter int BaudGeneratorAccWidth = 16,
  parameter int FifoDepth             = 4,
  parameter int FifoAW                = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              TxD_start,
  input  logic [7:0]        TxD_data,
  output logic              TxD_ready,
  output logic              TxD,
  output logic              TxD_busy,
  output logic [FifoAW:0]   fifo_level,
  output logic [3:0]        txState
);

  localparam int W = BaudGeneratorAccWidth;

  // Rounded fixed-point ratio Baud/ClkFrequency, scaled by 2^W.
  localparam logic [63:0] IncWide =
    ((64'(Baud) << (W - 4)) + (64'(ClkFrequency) >> 5)) / (64'(ClkFrequency) >> 4);
  localparam logic [W:0] Inc = IncWide[W:0];

  localparam logic [FifoAW:0] LvlFull = (FifoAW + 1)'(FifoDepth);
  localparam logic [FifoAW:0] LvlOne  = (FifoAW + 1)'(1);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] START = 4'd1;
  localparam logic [3:0] B0    = 4'd2;
  localparam logic [3:0] B1    = 4'd3;
  localparam logic [3:0] B2    = 4'd4;
  localparam logic [3:0] B3    = 4'd5;
  localparam logic [3:0] B4    = 4'd6;
  localparam logic [3:0] B5    = 4'd7;
  localparam logic [3:0] B6    = 4'd8;
  localparam logic [3:0] B7    = 4'd9;
  localparam logic [3:0] STOP  = 4'd10;

  logic [3:0]        state;
  logic [W:0]        acc;
  logic              baudTick;
  logic [7:0]        shiftReg;
  logic [7:0]        mem [FifoDepth];
  logic [FifoAW:0]   wrPtr;
  logic [FifoAW:0]   rdPtr;
  logic [FifoAW:0]   level;
  logic [FifoAW:0]   levelNext;
  logic              push;
  logic              pop;
  logic              notEmpty;

  assign baudTick   = acc[W];
  assign notEmpty   = (level != '0);
  assign push       = TxD_start && TxD_ready;
  // Pop whenever the serializer is ready to load a new byte.
  assign pop        = notEmpty && ((state == IDLE) || ((state == STOP) && baudTick));
  assign TxD_busy   = (state != IDLE);
  assign fifo_level = level;
  assign txState    = state;

  // Baud accumulator: parked at zero while idle, free-running otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (state == IDLE) begin
      acc <= '0;
    end else begin
      acc <= {1'b0, acc[W-1:0]} + Inc;
    end
  end

  // Next FIFO occupancy from this cycle's push and pop.
  always_comb begin
    levelNext = level;
    case ({push, pop})
      2'b10:   levelNext = level + LvlOne;
      2'b01:   levelNext = level - LvlOne;
      default: levelNext = level;
    endcase
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr[FifoAW-1:0]] <= TxD_data;
    end
  end

  // FIFO pointers, occupancy and registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      level     <= '0;
      TxD_ready <= 1'b1;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + LvlOne;
      end
      if (pop) begin
        rdPtr <= rdPtr + LvlOne;
      end
      level     <= levelNext;
      TxD_ready <= (levelNext != LvlFull);
    end
  end

  // Serializer FSM; TxD is registered together with each state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      TxD      <= 1'b1;
      shiftReg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (notEmpty) begin
            shiftReg <= mem[rdPtr[FifoAW-1:0]];
            state    <= START;
            TxD      <= 1'b0;
          end
        end
        START: begin
          if (baudTick) begin
            state <= B0;
            TxD   <= shiftReg[0];
          end
        end
        B0, B1, B2, B3, B4, B5, B6, B7: begin
          if (baudTick) begin
            shiftReg <= shiftReg >> 1;
            if (state == B7) begin
              state <= STOP;
              TxD   <= 1'b1;
            end else begin
              state <= state + 4'd1;
              TxD   <= shiftReg[1];
            end
          end
        end
        STOP: begin
          if (baudTick) begin
            if (notEmpty) begin
              shiftReg <= mem[rdPtr[FifoAW-1:0]];
              state    <= START;
              TxD      <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          TxD   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized bursts against a queue-based reference model,
// with a line-level receiver that decodes frames from TxD.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int CLK_HZ = 1152000;
  localparam int BAUD   = 115200;
  localparam int DEPTH  = 4;
  localparam int AW     = 2;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic          txd;
  logic          tx_busy;
  logic [AW:0]   fifo_level;
  logic [3:0]    tx_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(
    .ClkFrequency(CLK_HZ),
    .Baud(BAUD),
    .BaudGeneratorAccWidth(16),
    .FifoDepth(DEPTH),
    .FifoAW(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .TxD_start(tx_start),
    .TxD_data(tx_data),
    .TxD_ready(tx_ready),
    .TxD(txd),
    .TxD_busy(tx_busy),
    .fifo_level(fifo_level),
    .txState(tx_state)
  );

  // ---------------- scoreboard state ----------------
  int n_vectors    = 0;
  int n_miscompares = 0;
  logic [7:0] exp_q[$];
  int start_t[$];
  int rx_epoch = 0;
  logic rx_busy = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model: starting from idle, byte k of a back-to-back burst sees the FIFO
  // holding k bytes except that byte 0 leaves for the serializer one cycle later.
  function automatic int exp_level(input int k);
    if (k < 1) return 1;
    if (k > DEPTH) return DEPTH;
    return k;
  endfunction

  // ---------------- line receiver ----------------
  initial begin : rx_proc
    int ep;
    logic [7:0] b;
    logic st_bit;
    logic sp_bit;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && txd === 1'b0) begin
        ep = rx_epoch;
        rx_busy = 1'b1;
        start_t.push_back(cyc);
        repeat (5) @(negedge clk);
        st_bit = txd;
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(negedge clk);
          b[i] = txd;
        end
        repeat (10) @(negedge clk);
        sp_bit = txd;
        if (ep == rx_epoch) begin
          check_val("rx_start_bit", st_bit, 0);
          check_val("rx_stop_bit", sp_bit, 1);
          if (exp_q.size() == 0) check_val("rx_extra_frame", exp_q.size(), 1);
          else check_val("rx_byte", b, exp_q.pop_front());
        end
        rx_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called right after a negedge; returns one negedge later (after the edge).
  task automatic push_byte(input logic [7:0] b, input logic exp_acc);
    check_val("ready_at_push", tx_ready, exp_acc);
    tx_start = 1'b1;
    tx_data  = b;
    if (exp_acc) exp_q.push_back(b);
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((tx_busy || fifo_level != 0 || rx_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_val("idle_timeout", n < 3000, 1);
    repeat (3) @(negedge clk);
    check_val("rx_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Back-to-back burst from idle; frames spaced 10 bits, first one a clock longer.
  task automatic run_burst(input logic [7:0] bytes[$]);
    int n;
    int acc_n;
    n = bytes.size();
    acc_n = (n > DEPTH + 1) ? DEPTH + 1 : n;
    start_t.delete();
    for (int k = 0; k < n; k++) begin
      push_byte(bytes[k], k <= DEPTH);
      check_val("burst_level", fifo_level, exp_level(k));
      if (k == DEPTH) check_val("ready_fall_full", tx_ready, 0);
    end
    wait_idle();
    check_val("frame_count", start_t.size(), acc_n);
    for (int i = 1; i < start_t.size(); i++)
      check_val("frame_spacing", start_t[i] - start_t[i-1], (i == 1) ? 101 : 100);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [7:0] bq[$];
    int n;
    int lows;
    rst_n    = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;

    // Reset state
    repeat (5) @(negedge clk);
    check_val("rst_txd", txd, 1);
    check_val("rst_busy", tx_busy, 0);
    check_val("rst_ready", tx_ready, 1);
    check_val("rst_level", fifo_level, 0);
    check_val("rst_state", tx_state, 0);
    rst_n = 1'b1;
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check_val("idle_line_lows", lows, 0);
    check_val("idle_ready", tx_ready, 1);
    check_val("idle_no_frames", start_t.size(), 0);

    // Single byte: latency, busy length, decode
    start_t.delete();
    push_byte(8'h55, 1'b1);
    check_val("lat_c0_txd", txd, 1);
    check_val("lat_c0_level", fifo_level, 1);
    @(negedge clk);
    check_val("lat_c1_txd", txd, 0);
    check_val("lat_c1_busy", tx_busy, 1);
    check_val("lat_c1_level", fifo_level, 0);
    n = 1;
    while (tx_busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_val("busy_len", n - 1, 101);
    wait_idle();

    // Directed burst
    bq = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    run_burst(bq);

    // Directed overflow: six pushes, five frames
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_burst(bq);

    // Randomized bursts
    for (int it = 0; it < 6; it++) begin
      bq.delete();
      n = $urandom_range(1, 7);
      for (int k = 0; k < n; k++) bq.push_back(8'($urandom));
      run_burst(bq);
    end

    // Random mid-frame push chains directly after the current frame
    for (int it = 0; it < 3; it++) begin
      start_t.delete();
      push_byte(8'($urandom), 1'b1);
      repeat ($urandom_range(3, 85)) @(negedge clk);
      push_byte(8'($urandom), 1'b1);
      check_val("midframe_level", fifo_level, 1);
      wait_idle();
      check_val("midframe_frames", start_t.size(), 2);
      if (start_t.size() == 2) check_val("midframe_spacing", start_t[1] - start_t[0], 101);
    end

    // Push landing on the stop-bit tick edge with an empty FIFO
    start_t.delete();
    push_byte(8'h96, 1'b1);
    repeat (101) @(negedge clk);
    push_byte(8'h3A, 1'b1);
    wait_idle();
    check_val("stoptick_frames", start_t.size(), 2);
    if (start_t.size() == 2) check_val("stoptick_spacing", start_t[1] - start_t[0], 102);

    // Reset in the middle of B3 drops everything
    start_t.delete();
    push_byte(8'h0F, 1'b1);
    push_byte(8'hAA, 1'b1);
    repeat (44) @(negedge clk);
    check_val("pre_rst_busy", tx_busy, 1);
    exp_q.delete();
    rx_epoch++;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_txd", txd, 1);
    check_val("async_rst_busy", tx_busy, 0);
    check_val("async_rst_level", fifo_level, 0);
    check_val("async_rst_ready", tx_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start_t.delete();
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check_val("post_rst_lows", lows, 0);
    check_val("post_rst_level", fifo_level, 0);
    check_val("post_rst_frames", start_t.size(), 0);

    // One more byte after reset goes out intact
    push_byte(8'hC3, 1'b1);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

  // Hard time limit
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- RS-232 8N1 transmitter with a small input FIFO; pairs with the instrument controller's serial receiver on the host link.
- Accepts bytes on a valid/ready strobe and buffers them, so bursts (packets) go out back-to-back with no idle gap between frames.
- Serializes LSB-first: 1 start bit, 8 data bits, 1 stop bit.
- Bit timing comes from a fractional phase-accumulator baud generator; no integer divider.

Parameters:
- ClkFrequency, 25000000, clk frequency in Hz.
- Baud, 115200, line bit rate.
- BaudGeneratorAccWidth, 16, accumulator fraction width.
- FifoDepth, 4, number of FIFO entries; power of 2, minimum 2.
- FifoAW, 2, log2(FifoDepth).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- TxD_start  in  1  write strobe; byte accepted on a posedge where TxD_start && TxD_ready.
- TxD_data  in  8  byte to send; sampled with TxD_start.
- TxD_ready  out  1  FIFO not full; registered.
- TxD  out  1  serial line, idle high; registered.
- TxD_busy  out  1  serializer not IDLE.
- fifo_level  out  FifoAW+1  number of bytes currently buffered, 0..FifoDepth.

Behaviour:
- Reset values: TxD=1, TxD_busy=0, TxD_ready=1, fifo_level=0, FIFO pointers=0, accumulator=0, state=IDLE. Reset mid-frame aborts the frame immediately and drops all queued bytes.
- Baud generator:
  - Inc = ((Baud<<(W-4))+(ClkFrequency>>5))/(ClkFrequency>>4), with W = BaudGeneratorAccWidth; computed at elaboration, (W+1) bits wide.
  - Acc <= Acc[W-1:0] + Inc. BaudTick = Acc[W].
  - Acc is held at 0 while state==IDLE and runs otherwise.
- FIFO:
  - Circular buffer with (FifoAW+1)-bit read and write pointers; pointers wrap naturally.
  - Push when TxD_start && TxD_ready. TxD_start while full is ignored; the byte is lost and no state changes.
  - TxD_ready is derived from the registered level. When full, a push is rejected even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: fifo_level is unchanged and both pointers advance.
- FSM states: IDLE, START, B0..B7, STOP. On each state entry below, TxD is registered to the stated value on that same edge.
  - IDLE: if fifo_level != 0, pop into an 8-bit shift register, enter START, TxD<=0.
  - START: on BaudTick, enter B0, TxD<=shift[0].
  - Bn: on BaudTick, shift right; enter B(n+1) with TxD<=next bit, or from B7 enter STOP with TxD<=1.
  - STOP: on BaudTick, if FIFO is non-empty, pop, enter START, TxD<=0, with Acc not cleared (back-to-back frames); otherwise enter IDLE.
- Timing:
  - Each bit lasts one BaudTick interval, i.e. ClkFrequency/Baud clocks ±1.
  - Latency from idle: the push edge is cycle 0; the pop happens at cycle 1; TxD falls at the cycle-1 edge, visible from cycle 1 onward.
  - Frame length is 10 bit periods.
- TxD_busy = (state != IDLE), combinational from the state register.
- TxD_data may change freely after acceptance.

Test Plan:
- Timing setup: ClkFrequency=1152000, Baud=115200. This gives Inc=6554, so a bit is 10 clocks, with an occasional 9.
- Reset: hold rst_n=0, then release -> TxD=1, TxD_ready=1, fifo_level=0, TxD_busy=0; TxD stays 1 for 200 clocks with no push.
- Single byte: push 0x55 -> TxD goes low 1 cycle later; line pattern 0,1,0,1,0,1,0,1,0,1, each bit 10±1 clocks; TxD_busy falls about 100 clocks after start; a bench receiver decodes 0x55.
- Burst: push 0xA5,0x3C,0xFF,0x00 on consecutive cycles -> fifo_level peaks at 3 (one byte is popped immediately); 4 frames with the stop bit immediately followed by the next start bit; the receiver decodes the bytes in order.
- Overflow: push 6 bytes on consecutive cycles while the first is sending -> TxD_ready falls when fifo_level=4; bytes 6+ are dropped; exactly 5 frames are transmitted.
- Reset mid-frame: push 0x0F, assert rst_n=0 during B3 -> TxD=1 immediately (async); after release, no residual frame and fifo_level=0.
- Push on the STOP-tick cycle with an empty FIFO -> the byte is accepted; the FSM goes IDLE then START 1 cycle later; the gap is at most 2 clocks and the byte decodes correctly.
